fp_sequence_engine: RTL and testbench

Parametrised IEEE-754 single-precision sequence generator, successor to the arithmetic sequence generator. Produces n terms of a1 ± k·d by repeated accumulation through the shared fp_adder, which uses a start/done handshake and has variable latency. Supports three modes: ascending, descending, and periodic restart. A write-buffer FIFO decouples term production from memory backpressure. Sits between the control CSRs and the memory write port, with a valid/ready write interface and an abort path.

---
 rtl/fp_sequence_engine.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_fp_sequence_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sequence_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fp_sequence_engine (with local fp_adder)
//  Description : FP32 arithmetic-sequence generator. Terms a1 +/- k*d are built
//                by repeated accumulation through a start/done FP adder,
//                buffered in a small FIFO and written out over a valid/ready
//                memory port. Supports ascending, descending and periodic
//                restart modes, plus abort.
//  Revision    : 1.0 - initial release
// ============================================================================

// Multi-cycle FP32 adder. Round-to-nearest-even; denormal inputs are treated
// as zero, underflow flushes to zero and overflow saturates to infinity.
// Latency varies with the operands (1..4 cycles after start).
module fp_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] result
);
    logic [31:0] r_a, r_b;
    logic [1:0]  r_cnt;
    logic        r_run, r_done;

    logic              w_swap;
    logic [31:0]       w_big, w_sml;
    logic [26:0]       w_mbig, w_msml, w_shifted, w_lost, w_aligned, w_norm;
    logic [7:0]        w_diff;
    logic [27:0]       w_sum;
    logic signed [9:0] w_exp, w_lz;
    logic              w_up;
    logic [24:0]       w_rnd;
    logic [23:0]       w_mant;

    // Capture operands on start and count down an operand-dependent latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_cnt  <= a[24:23] ^ b[24:23];
            r_run  <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_run) begin
                if (r_cnt == 2'd0) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end
        end
    end

    // Align, add/subtract, normalise and round the held operands.
    always_comb begin
        w_swap    = (r_b[30:0] > r_a[30:0]);
        w_big     = w_swap ? r_b : r_a;
        w_sml     = w_swap ? r_a : r_b;
        w_mbig    = (w_big[30:23] == 8'd0) ? 27'd0 : {1'b1, w_big[22:0], 3'b000};
        w_msml    = (w_sml[30:23] == 8'd0) ? 27'd0 : {1'b1, w_sml[22:0], 3'b000};
        w_diff    = w_big[30:23] - w_sml[30:23];
        w_shifted = w_msml >> w_diff;
        w_lost    = w_msml & ~({27{1'b1}} << w_diff);
        w_aligned = {w_shifted[26:1], w_shifted[0] | (|w_lost)};
        w_sum     = (w_big[31] == w_sml[31]) ? ({1'b0, w_mbig} + {1'b0, w_aligned})
                                             : ({1'b0, w_mbig} - {1'b0, w_aligned});
        w_exp     = $signed({2'b00, w_big[30:23]});
        w_lz      = 10'sd0;
        for (int i = 0; i < 27; i++) begin
            if (w_sum[i]) w_lz = 10'(26 - i);
        end
        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp  = w_exp + 10'sd1;
        end else begin
            w_norm = w_sum[26:0] << w_lz;
            w_exp  = w_exp - w_lz;
        end
        w_up  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd = {1'b0, w_norm[26:3]} + {24'd0, w_up};
        if (w_rnd[24]) begin
            w_mant = w_rnd[24:1];
            w_exp  = w_exp + 10'sd1;
        end else begin
            w_mant = w_rnd[23:0];
        end
        if (w_sum == 28'd0)
            result = 32'd0;
        else if (w_exp <= 10'sd0)
            result = {w_big[31], 31'd0};
        else if (w_exp >= 10'sd255)
            result = {w_big[31], 8'hFF, 23'd0};
        else
            result = {w_big[31], w_exp[7:0], w_mant[22:0]};
    end

    assign done = r_done;
endmodule

module fp_sequence_engine #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32,
    parameter int STRIDE = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              activate,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [31:0]       a1,
    input  logic [31:0]       d,
    input  logic [CNT_W-1:0]  n,
    input  logic [CNT_W-1:0]  period,
    input  logic [ADDR_W-1:0] saddr,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  terms_written,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    input  logic              mem_ready
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SEED  = 3'd1;
    localparam logic [2:0] c_ISSUE = 3'd2;
    localparam logic [2:0] c_WAIT  = 3'd3;
    localparam logic [2:0] c_PUSH  = 3'd4;
    localparam logic [2:0] c_DRAIN = 3'd5;
    localparam logic [2:0] c_FLUSH = 3'd6;

    logic [2:0]        r_state;
    logic [31:0]       r_a1, r_d, r_cur;
    logic [CNT_W-1:0]  r_n, r_period, r_pushed, r_ph, r_tw;
    logic              r_periodic, r_done, r_aborted;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_rd, r_wr;
    logic [AW:0]       r_count;

    logic              w_accept, w_pop, w_full, w_complete, w_abort;
    logic              w_push_req, w_push, w_restart, w_add_start, w_add_done;
    logic [CNT_W-1:0]  w_ph_inc, w_ph_next, w_pushed_inc;
    logic [31:0]       w_add_sum;

    assign busy         = (r_state != c_IDLE);
    assign w_accept     = activate && (r_state == c_IDLE);
    assign w_pop        = (r_count != '0) && mem_ready;
    assign w_full       = (r_count == (AW+1)'(DEPTH));
    assign w_complete   = (r_state == c_DRAIN) && (r_tw == r_n);
    assign w_abort      = abort && busy && (r_state != c_FLUSH) && !w_complete;
    assign w_push_req   = (r_state == c_PUSH) || ((r_state == c_SEED) && (r_n != '0));
    // A full FIFO still accepts a push when the head pops on the same edge.
    assign w_push       = w_push_req && (!w_full || w_pop) && !w_abort;
    assign w_ph_inc     = r_ph + 1'b1;
    // Phase of the next term within the period; period 0/1 keeps it at zero.
    assign w_ph_next    = (w_ph_inc >= r_period) ? '0 : w_ph_inc;
    assign w_restart    = r_periodic && (w_ph_next == '0);
    assign w_pushed_inc = r_pushed + 1'b1;
    assign w_add_start  = (r_state == c_ISSUE) && !w_abort;

    fp_adder u_adder (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_add_start),
        .a      (r_cur),
        .b      (r_d),
        .done   (w_add_done),
        .result (w_add_sum)
    );

    // Producer FSM: seeds a1, accumulates via the adder, restarts in periodic mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_a1       <= '0;
            r_d        <= '0;
            r_cur      <= '0;
            r_n        <= '0;
            r_period   <= '0;
            r_periodic <= 1'b0;
            r_pushed   <= '0;
            r_ph       <= '0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
        end else if (r_state == c_IDLE) begin
            if (w_accept) begin
                r_a1       <= a1;
                r_d        <= {d[31] ^ mode[0], d[30:0]};
                r_cur      <= a1;
                r_n        <= n;
                r_period   <= period;
                r_periodic <= mode[1];
                r_pushed   <= '0;
                r_ph       <= '0;
                r_done     <= 1'b0;
                r_aborted  <= 1'b0;
                r_state    <= c_SEED;
            end
        end else if (w_complete) begin
            r_done  <= 1'b1;
            r_state <= c_IDLE;
        end else if (w_abort) begin
            r_state <= c_FLUSH;
        end else begin
            case (r_state)
                c_SEED, c_PUSH: begin
                    if ((r_state == c_SEED) && (r_n == '0)) begin
                        r_state <= c_DRAIN;
                    end else if (w_push) begin
                        r_pushed <= w_pushed_inc;
                        r_ph     <= w_ph_next;
                        if (w_pushed_inc == r_n) begin
                            r_state <= c_DRAIN;
                        end else if (w_restart) begin
                            r_cur   <= r_a1;
                            r_state <= c_PUSH;
                        end else begin
                            r_state <= c_ISSUE;
                        end
                    end
                end
                c_ISSUE: r_state <= c_WAIT;
                c_WAIT: begin
                    if (w_add_done) begin
                        r_cur   <= w_add_sum;
                        r_state <= c_PUSH;
                    end
                end
                c_DRAIN: r_state <= c_DRAIN;
                c_FLUSH: begin
                    if (r_count == '0) begin
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                        r_state   <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Write buffer and writer: head is presented until accepted; abort keeps
    // only a presented-but-unaccepted head and drops the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_tw    <= '0;
            r_addr  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_accept) begin
                r_tw   <= '0;
                r_addr <= saddr;
            end else if (w_pop) begin
                r_tw   <= r_tw + 1'b1;
                r_addr <= r_addr + ADDR_W'(STRIDE);
            end
            if (w_abort) begin
                r_rd    <= r_rd + AW'(w_pop);
                r_wr    <= r_rd + AW'(r_count != '0);
                r_count <= ((r_count != '0) && !w_pop) ? (AW+1)'(1) : '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr] <= r_cur;
                    r_wr        <= r_wr + 1'b1;
                end
                if (w_pop) r_rd <= r_rd + 1'b1;
                if (w_push && !w_pop)
                    r_count <= r_count + 1'b1;
                else if (!w_push && w_pop)
                    r_count <= r_count - 1'b1;
            end
        end
    end

    assign done          = r_done;
    assign aborted       = r_aborted;
    assign terms_written = r_tw;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_mem[r_rd];
    assign mem_write     = (r_count != '0);
endmodule
`default_nettype wire

// File: tb/tb_fp_sequence_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_sequence_engine
//  Description : Self-checking bench for fp_sequence_engine. Terms are kept as
//                exact multiples of 0.5 so the reference is plain integer math.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_sequence_engine;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 32;
    localparam int STRIDE = 4;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              activate = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [31:0]       a1 = '0, d = '0;
    logic [CNT_W-1:0]  n = '0, period = '0;
    logic [ADDR_W-1:0] saddr = '0;
    logic              busy, done, aborted, mem_write;
    logic [CNT_W-1:0]  terms_written;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready = 1'b0;

    fp_sequence_engine #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .STRIDE(STRIDE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .activate(activate), .abort(abort), .mode(mode),
        .a1(a1), .d(d), .n(n), .period(period), .saddr(saddr), .busy(busy),
        .done(done), .aborted(aborted), .terms_written(terms_written),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] got_data[$];
    int          widx, starts, exp_starts;
    logic        prev_pend;
    logic [31:0] prev_addr, prev_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Exact FP32 encoding of h/2.
    function automatic logic [31:0] to_fp(input int h);
        int   m, p;
        logic s;
        if (h == 0) return 32'd0;
        s = (h < 0);
        m = s ? -h : h;
        p = 0;
        for (int i = 0; i < 31; i++) if (m[i]) p = i;
        return {s, 8'(127 + p - 1), 23'((m << (23 - p)) & 32'h7FFFFF)};
    endfunction

    // Term k in halves: a1 +/- (k, or k mod period in periodic mode) * d.
    function automatic int term_h(input int a1h, input int dh, input logic [1:0] md,
                                  input int per, input int k);
        int kk;
        if (md[1]) kk = (per <= 1) ? 0 : (k % per);
        else       kk = k;
        return md[0] ? (a1h - kk * dh) : (a1h + kk * dh);
    endfunction

    // One clock: check held outputs, drive ready, score any handshake.
    task automatic cyc(input bit rdy);
        @(negedge clk);
        if (prev_pend) begin
            chk("hold_valid", mem_write, 1);
            chk("hold_addr", mem_addr, prev_addr);
            chk("hold_data", mem_wdata, prev_data);
        end
        mem_ready = rdy;
        if (dut.w_add_start) starts++;
        if (mem_write && rdy) begin
            if (widx < exp_data.size()) begin
                chk($sformatf("addr[%0d]", widx), mem_addr, exp_addr[widx]);
                chk($sformatf("data[%0d]", widx), mem_wdata, exp_data[widx]);
                got_data.push_back(mem_wdata);
            end else begin
                chk("extra_write_idx", widx, exp_data.size());
            end
            widx++;
        end
        prev_pend = mem_write && !rdy;
        prev_addr = mem_addr;
        prev_data = mem_wdata;
    endtask

    task automatic launch(input int a1h, input int dh, input logic [1:0] md, input int nn,
                          input int per, input logic [31:0] sa, input bit rdy0);
        exp_data.delete(); exp_addr.delete(); got_data.delete();
        exp_starts = 0;
        for (int k = 0; k < nn; k++) begin
            exp_data.push_back(to_fp(term_h(a1h, dh, md, per, k)));
            exp_addr.push_back(sa + 32'(k * STRIDE));
            if (k > 0 && !(md[1] && (per <= 1 || (k % per) == 0))) exp_starts++;
        end
        widx = 0; starts = 0; prev_pend = 1'b0;
        @(negedge clk);
        a1 = to_fp(a1h); d = to_fp(dh); mode = md; n = nn; period = per; saddr = sa;
        activate = 1'b1;
        cyc(rdy0);
        activate = 1'b0;
        chk("acc_busy", busy, 1);
        chk("acc_done", done, 0);
        chk("acc_tw", terms_written, 0);
    endtask

    task automatic run(input int a1h, input int dh, input logic [1:0] md, input int nn,
                       input int per, input logic [31:0] sa, input int pct, input int hold);
        int c;
        bit rdy;
        launch(a1h, dh, md, nn, per, sa, hold == 0);
        c = 1;
        while (!done && c < 3000) begin
            rdy = (c < hold) ? 1'b0 : ($urandom_range(1, 100) <= pct);
            cyc(rdy);
            if (hold > 0 && c == hold - 1) begin
                chk("fifo_full_count", dut.r_count, DEPTH);
                chk("stalled_pushes", dut.r_pushed, DEPTH);
                chk("stalled_no_write", widx, 0);
            end
            c++;
        end
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_aborted", aborted, 0);
        chk("end_tw", terms_written, nn);
        chk("end_writes", widx, nn);
        chk("adder_starts", starts, exp_starts);
    endtask

    initial begin
        int c;
        #10000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_tw", terms_written, 0);
        rst_n = 1'b1;

        // Ascending 1.0 step 0.5
        run(2, 1, 2'b00, 4, 0, 32'h100, 100, 0);
        if (got_data.size() == 4) begin
            chk("t1_w0", got_data[0], 32'h3F800000);
            chk("t1_w1", got_data[1], 32'h3FC00000);
            chk("t1_w2", got_data[2], 32'h40000000);
            chk("t1_w3", got_data[3], 32'h40200000);
        end else chk("t1_count", got_data.size(), 4);

        // Descending 2.0 step 0.5
        run(4, 1, 2'b01, 3, 0, 32'h200, 100, 0);
        if (got_data.size() == 3) begin
            chk("t2_w0", got_data[0], 32'h40000000);
            chk("t2_w1", got_data[1], 32'h3FC00000);
            chk("t2_w2", got_data[2], 32'h3F800000);
        end else chk("t2_count", got_data.size(), 3);

        // Periodic restart, period 2: two adder starts
        run(2, 1, 2'b10, 5, 2, 32'h300, 100, 0);
        chk("t3_starts", starts, 2);

        // Backpressure: 30 cycles of ready low
        run(3, 1, 2'b00, 8, 0, 32'h400, 100, 30);

        // Address wrap
        run(2, 1, 2'b00, 4, 0, 32'hFFFFFFF8, 100, 0);
        if (got_data.size() == 4) chk("wrap_last_addr", exp_addr[3], 32'h00000004);

        // n = 0: done exactly two cycles after accept, no writes
        launch(2, 1, 2'b00, 0, 0, 32'h500, 1'b1);
        cyc(1'b1);
        chk("n0_busy_c1", busy, 1);
        chk("n0_done_c1", done, 0);
        chk("n0_write_c1", mem_write, 0);
        cyc(1'b1);
        chk("n0_done_c2", done, 1);
        chk("n0_busy_c2", busy, 0);
        chk("n0_writes", widx, 0);

        // Abort after 2nd acceptance with 3rd presented
        launch(2, 1, 2'b00, 10, 0, 32'h600, 1'b1);
        c = 0;
        while (widx < 2 && c < 200) begin cyc(1'b1); c++; end
        cyc(1'b0);
        c = 0;
        while (!mem_write && c < 200) begin cyc(1'b0); c++; end
        chk("ab_presented", mem_write, 1);
        abort = 1'b1;
        cyc(1'b1);
        abort = 1'b0;
        chk("ab_held_valid", mem_write, 1);
        c = 0;
        while (!done && c < 200) begin cyc(1'b1); c++; end
        chk("ab_done", done, 1);
        chk("ab_aborted", aborted, 1);
        chk("ab_busy", busy, 0);
        chk("ab_tw", terms_written, 3);
        chk("ab_writes", widx, 3);
        cyc(1'b1);
        chk("ab_quiet", mem_write, 0);

        // Randomised runs
        for (int r = 0; r < 8; r++) begin
            run(int'($urandom_range(0, 80)) - 40, int'($urandom_range(0, 16)) - 8,
                2'($urandom_range(0, 3)), int'($urandom_range(1, 12)),
                int'($urandom_range(0, 4)), $urandom & 32'hFFFFFFFC,
                int'($urandom_range(30, 100)), 0);
        end

        // Asynchronous reset mid-run
        launch(2, 1, 2'b00, 10, 0, 32'h700, 1'b1);
        repeat (4) cyc(1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_write", mem_write, 0);
        chk("mrst_tw", terms_written, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
